// File: rtl/activation_engine.sv
// activation_engine: multi-lane runtime-configurable activation (ReLU / leaky / clipped / bypass)
// behind a 2-stage AXI-Stream pipeline. Define ACT_ENGINE_STATS_EN to build the stat_count counter.

module act_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            mode,
  input  logic [4:0]            shift,
  input  logic [DATA_WIDTH-1:0] clip,
  input  logic [DATA_WIDTH-1:0] x,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  modified
);
  logic signed [DATA_WIDTH-1:0] xs;
  logic                         neg;

  assign xs  = $signed(x);
  assign neg = x[DATA_WIDTH-1];

  // Non-negative x makes the clip compare a plain unsigned compare against the ceiling.
  always_comb begin
    y = x;
    unique case (mode)
      2'd0: if (neg) y = '0;
      2'd1: if (neg) y = xs >>> shift;
      2'd2: if (neg) y = '0; else if (x > clip) y = clip;
      default: y = x;
    endcase
  end

  assign modified = (y != x);
endmodule

module activation_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int FRAC_BITS  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [LANES*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [LANES*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tlast,
  input  logic [1:0]                  cfg_mode,
  input  logic [4:0]                  cfg_shift,
  input  logic [DATA_WIDTH-1:0]       cfg_clip,
  output logic                        pkt_active,
  output logic [31:0]                 stat_count
);
  localparam int STAGES = 2;

  if (FRAC_BITS >= DATA_WIDTH) begin : g_bad_frac
    $error("FRAC_BITS must be smaller than DATA_WIDTH");
  end

  typedef struct packed {
    logic [1:0]            mode;
    logic [4:0]            shift;
    logic [DATA_WIDTH-1:0] clip;
  } cfg_t;

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t                             state;
  cfg_t                               live_cfg, lat_cfg, eff_cfg, s1_cfg;
  logic [STAGES:1]                    vld_pipe;
  logic                               ld1, ld2, accept;
  logic [LANES-1:0][DATA_WIDTH-1:0]   s1_data, lane_y, m_data;
  logic                               s1_last;
  logic [LANES-1:0]                   lane_mod;

  assign ld2           = !vld_pipe[2] || m_axis_tready;
  assign ld1           = !vld_pipe[1] || ld2;
  assign s_axis_tready = !reset && ld1;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign live_cfg      = '{mode: cfg_mode, shift: cfg_shift, clip: cfg_clip};
  // First beat of a packet sees the live config; the rest see the latched copy.
  assign eff_cfg       = (state == IDLE) ? live_cfg : lat_cfg;
  assign m_axis_tvalid = vld_pipe[2];
  assign m_axis_tdata  = m_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lat_cfg    <= '0;
      pkt_active <= 1'b0;
    end else if (accept) begin
      if (state == IDLE) lat_cfg <= live_cfg;
      state      <= s_axis_tlast ? IDLE : IN_PKT;
      pkt_active <= !s_axis_tlast;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe     <= '0;
      s1_data      <= '0;
      s1_last      <= 1'b0;
      s1_cfg       <= '0;
      m_data       <= '0;
      m_axis_tlast <= 1'b0;
    end else begin
      if (ld1) begin
        vld_pipe[1] <= accept;
        if (accept) begin
          s1_data <= s_axis_tdata;
          s1_last <= s_axis_tlast;
          s1_cfg  <= eff_cfg;
        end
      end
      if (ld2) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          m_data       <= lane_y;
          m_axis_tlast <= s1_last;
        end
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    act_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .mode     (s1_cfg.mode),
      .shift    (s1_cfg.shift),
      .clip     (s1_cfg.clip),
      .x        (s1_data[i]),
      .y        (lane_y[i]),
      .modified (lane_mod[i])
    );
  end

`ifdef ACT_ENGINE_STATS_EN
  localparam int CW = $clog2(LANES + 1);
  logic [CW-1:0] mod_cnt, s2_mod_cnt;
  logic [32:0]   stat_sum;

  always_comb begin
    mod_cnt = '0;
    for (int i = 0; i < LANES; i++) mod_cnt = mod_cnt + CW'(lane_mod[i]);
  end

  assign stat_sum = {1'b0, stat_count} + 33'(s2_mod_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_mod_cnt <= '0;
      stat_count <= '0;
    end else begin
      if (ld2 && vld_pipe[1]) s2_mod_cnt <= mod_cnt;
      if (m_axis_tvalid && m_axis_tready) stat_count <= stat_sum[32] ? '1 : stat_sum[31:0];
    end
  end
`else
  logic unused_mod;
  assign unused_mod = ^lane_mod;
  assign stat_count = '0;
`endif
endmodule

// File: tb/tb_activation_engine.sv
// Scoreboard bench for activation_engine: directed activation vectors, config latching,
// backpressure, back-to-back packets and reset recovery.
module tb_activation_engine;
  localparam int DW = 32;
  localparam int LN = 4;
  localparam int W  = DW * LN;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
  logic [W-1:0]  s_axis_tdata = '0;
  logic          m_axis_tvalid, m_axis_tready = 1'b1, m_axis_tlast;
  logic [W-1:0]  m_axis_tdata;
  logic [1:0]    cfg_mode = 2'd0;
  logic [4:0]    cfg_shift = 5'd0;
  logic [DW-1:0] cfg_clip = '0;
  logic          pkt_active;
  logic [31:0]   stat_count;

  activation_engine #(.DATA_WIDTH(DW), .LANES(LN), .FRAC_BITS(16)) dut (
    .clk(clk), .reset(reset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .cfg_mode(cfg_mode), .cfg_shift(cfg_shift), .cfg_clip(cfg_clip),
    .pkt_active(pkt_active), .stat_count(stat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  data;
    logic          last;
    logic [1:0]    mode;
    logic [4:0]    shift;
    logic [DW-1:0] clip;
    logic [W-1:0]  exp_data;
  } stim_t;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    n_cmp = 0, n_err = 0;
  int    stall_cnt = 0;
  bit    done = 0;
  int    exp_stat = 0;

  function automatic logic [W-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {32'(a3), 32'(a2), 32'(a1), 32'(a0)};
  endfunction

  // Reference activation built from floor division rather than shifts.
  function automatic logic [DW-1:0] act_ref(input logic [DW-1:0] x, input logic [1:0] mode,
                                            input int sh, input logic [DW-1:0] clip);
    longint v, d, q;
    v = longint'($signed(x));
    case (mode)
      2'd0: return (v < 0) ? '0 : x;
      2'd1: begin
        if (v >= 0) return x;
        d = longint'(1) << sh;
        q = v / d;
        if (q * d != v) q = q - 1;
        return q[DW-1:0];
      end
      2'd2: begin
        if (v < 0) return '0;
        if (v > longint'({32'd0, clip})) return clip;
        return x;
      end
      default: return x;
    endcase
  endfunction

  function automatic logic [W-1:0] act_ref_beat(input logic [W-1:0] d, input logic [1:0] mode,
                                                input int sh, input logic [DW-1:0] clip);
    logic [W-1:0] r;
    for (int i = 0; i < LN; i++) r[i*DW +: DW] = act_ref(d[i*DW +: DW], mode, sh, clip);
    return r;
  endfunction

  function automatic stim_t mk(input logic [W-1:0] d, input logic l, input logic [1:0] m,
                               input logic [4:0] s, input logic [DW-1:0] c, input logic [W-1:0] e);
    stim_t t;
    t.data = d; t.last = l; t.mode = m; t.shift = s; t.clip = c; t.exp_data = e;
    return t;
  endfunction

  // pat: 0 = always ready, 1 = ready on every third cycle, 2 = random ready
  task automatic run_stream(input int pat, input string name);
    int n_exp;
    n_exp = stim_q.size();
    done = 0;
    stall_cnt = 0;
    fork
      begin
        while (stim_q.size() > 0) begin
          stim_t s;
          bit    acc;
          int    w;
          s = stim_q.pop_front();
          s_axis_tvalid = 1'b1; s_axis_tdata = s.data; s_axis_tlast = s.last;
          cfg_mode = s.mode; cfg_shift = s.shift; cfg_clip = s.clip;
          acc = 0; w = 0;
          while (!acc && w < 100) begin
            @(negedge clk); acc = s_axis_tready;
            @(posedge clk); #1; w++;
            if (!acc) stall_cnt++;
          end
          n_cmp++;
          if (!acc) begin
            n_err++;
            $display("FAIL %s input_accept: beat never accepted within 100 cycles", name);
          end else begin
            exp_q.push_back('{data: s.exp_data, last: s.last});
            if (pkt_active !== !s.last) begin
              n_err++;
              $display("FAIL %s pkt_active: got %b want %b", name, pkt_active, !s.last);
            end
          end
        end
        s_axis_tvalid = 1'b0;
      end
      begin
        int c;
        c = 0;
        while (!done && c < 3000) begin
          case (pat)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = (c % 3 == 0);
            default: m_axis_tready = 1'($urandom_range(0, 1));
          endcase
          @(posedge clk); #1; c++;
        end
        m_axis_tready = 1'b1;
      end
      begin
        int           got, cyc;
        bit           stall;
        logic [W-1:0] hd;
        logic         hl;
        exp_t         e;
        got = 0; cyc = 0; stall = 0; hd = '0; hl = 1'b0;
        while (got < n_exp && cyc < 40 * n_exp + 50) begin
          @(negedge clk); cyc++;
          if (stall) begin
            n_cmp++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hd || m_axis_tlast !== hl) begin
              n_err++;
              $display("FAIL %s stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                       name, m_axis_tvalid, m_axis_tdata, m_axis_tlast, hd, hl);
            end
          end
          if (m_axis_tvalid && m_axis_tready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
              n_err++;
              $display("FAIL %s extra_beat: got d=%h with nothing expected", name, m_axis_tdata);
            end else begin
              e = exp_q.pop_front();
              if (m_axis_tdata !== e.data || m_axis_tlast !== e.last) begin
                n_err++;
                $display("FAIL %s beat%0d: got d=%h l=%b want d=%h l=%b",
                         name, got, m_axis_tdata, m_axis_tlast, e.data, e.last);
              end
            end
            got++;
          end
          stall = m_axis_tvalid && !m_axis_tready;
          hd = m_axis_tdata; hl = m_axis_tlast;
        end
        if (got < n_exp) begin
          n_cmp++; n_err++;
          $display("FAIL %s output_timeout: got %0d beats want %0d", name, got, n_exp);
        end
        done = 1;
      end
    join
    @(negedge clk);
    n_cmp++;
    if (m_axis_tvalid !== 1'b0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s drain: got tvalid=%b pending=%0d want tvalid=0 pending=0",
               name, m_axis_tvalid, exp_q.size());
    end
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic check_stat(input string name);
    int want;
`ifdef ACT_ENGINE_STATS_EN
    want = exp_stat;
`else
    want = 0;
`endif
    n_cmp++;
    if (stat_count !== 32'(want)) begin
      n_err++;
      $display("FAIL %s stat_count: got %0d want %0d", name, stat_count, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 ||
        m_axis_tlast !== 1'b0 || pkt_active !== 1'b0 || stat_count !== '0) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%b v=%b d=%h l=%b act=%b st=%0d want all 0",
               s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, pkt_active, stat_count);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_stat = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1; s_axis_tdata = pack4(1, 2, 3, 4); s_axis_tlast = 1'b1; cfg_mode = 2'd0;
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    n_cmp++;
    if (m_axis_tvalid !== 1'b0) begin
      n_err++; $display("FAIL latency_early: got tvalid=%b want 0 one edge after accept", m_axis_tvalid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pack4(1, 2, 3, 4)) begin
      n_err++;
      $display("FAIL latency_out: got v=%b d=%h want v=1 d=%h", m_axis_tvalid, m_axis_tdata, pack4(1, 2, 3, 4));
    end
    @(posedge clk); #1;
    n_cmp++;
    if (m_axis_tvalid !== 1'b0) begin
      n_err++; $display("FAIL latency_dup: got tvalid=%b want 0", m_axis_tvalid);
    end
  endtask

  task automatic test_relu();
    stim_q.push_back(mk(pack4(32'h10, 32'hFFFFFFF0, 32'h80000010, 0), 1'b1, 2'd0, 5'd0, '0,
                        pack4(32'h10, 0, 0, 0)));
    run_stream(0, "relu");
    exp_stat += 2;
    check_stat("relu");
  endtask

  task automatic test_leaky();
    stim_q.push_back(mk(pack4(-64, -1, 100, -9), 1'b1, 2'd1, 5'd3, '0, pack4(-8, -1, 100, -2)));
    run_stream(0, "leaky");
    exp_stat += 2;
    check_stat("leaky");
  endtask

  task automatic test_clip();
    stim_q.push_back(mk(pack4(32'h00070000, 32'h00038000, 32'hFFFE0000, 32'h00060000), 1'b1,
                        2'd2, 5'd0, 32'h00060000,
                        pack4(32'h00060000, 32'h00038000, 0, 32'h00060000)));
    run_stream(0, "clip");
    exp_stat += 2;
    check_stat("clip");
  endtask

  task automatic test_leaky_bounds();
    stim_q.push_back(mk(pack4(-5, 7, 32'h80000000, -1), 1'b1, 2'd1, 5'd0, '0,
                        pack4(-5, 7, 32'h80000000, -1)));
    stim_q.push_back(mk(pack4(-5, 32'h80000000, 5, -1), 1'b1, 2'd1, 5'd31, '0,
                        pack4(-1, -1, 5, -1)));
    stim_q.push_back(mk(pack4(32'h7FFFFFFF, 32'h00060001, 0, 32'h00060000), 1'b1, 2'd2, 5'd0,
                        32'h00060000, pack4(32'h00060000, 32'h00060000, 0, 32'h00060000)));
    run_stream(0, "bounds");
  endtask

  task automatic test_cfg_latch();
    stim_q.push_back(mk(pack4(-3, 5, -7, 9), 1'b0, 2'd0, 5'd0, '0, pack4(0, 5, 0, 9)));
    stim_q.push_back(mk(pack4(-1, -2, 3, 4), 1'b0, 2'd3, 5'd0, '0, pack4(0, 0, 3, 4)));
    stim_q.push_back(mk(pack4(8, -8, -9, 1), 1'b1, 2'd3, 5'd0, '0, pack4(8, 0, 0, 1)));
    stim_q.push_back(mk(pack4(-1, -2, 3, -4), 1'b1, 2'd3, 5'd0, '0, pack4(-1, -2, 3, -4)));
    run_stream(0, "cfg_latch");
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d;
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      stim_q.push_back(mk(d, 1'(i % 4 == 3), 2'd1, 5'd2, '0, act_ref_beat(d, 2'd1, 2, '0)));
    end
    run_stream(1, "backpressure");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]  d;
    logic [1:0]    pm, lm;
    logic [DW-1:0] clip;
    clip = 32'h00060000;
    for (int i = 0; i < 12; i++) begin
      d = {$urandom, $urandom_range(0, 32'h000A0000), $urandom, $urandom_range(0, 32'h000A0000)};
      pm = 2'(i / 4);
      lm = (i % 4 == 0) ? pm : 2'($urandom_range(0, 3));
      stim_q.push_back(mk(d, 1'(i % 4 == 3), lm, 5'd4, clip, act_ref_beat(d, pm, 4, clip)));
    end
    run_stream(0, "back_to_back");
    n_cmp++;
    if (stall_cnt != 0) begin
      n_err++; $display("FAIL back_to_back throughput: got %0d input stalls want 0", stall_cnt);
    end
    for (int i = 0; i < 10; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      stim_q.push_back(mk(d, 1'(i % 5 == 4), 2'd1, 5'd1, '0, act_ref_beat(d, 2'd1, 1, '0)));
    end
    run_stream(2, "random_ready");
  endtask

  task automatic test_reset_mid();
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = pack4(-1, -2, -3, -4); s_axis_tlast = 1'b0; cfg_mode = 2'd3;
    repeat (4) begin @(posedge clk); #1; end
    n_cmp++;
    if (m_axis_tvalid !== 1'b1 || pkt_active !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_fill: got v=%b act=%b want v=1 act=1", m_axis_tvalid, pkt_active);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tlast !== 1'b0 ||
        pkt_active !== 1'b0 || s_axis_tready !== 1'b0 || stat_count !== '0) begin
      n_err++;
      $display("FAIL reset_mid_clear: got v=%b d=%h l=%b act=%b rdy=%b st=%0d want all 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tlast, pkt_active, s_axis_tready, stat_count);
    end
    s_axis_tvalid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_axis_tready = 1'b1;
    exp_stat = 0;
    stim_q.push_back(mk(pack4(-4, 6, -3, 0), 1'b1, 2'd1, 5'd1, '0, pack4(-2, 6, -2, 0)));
    run_stream(0, "reset_recover");
  endtask

  initial begin
    test_reset();
    test_latency();
    test_relu();
    test_leaky();
    test_clip();
    test_leaky_bounds();
    test_cfg_latch();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/activation_engine.md
Name: activation_engine

Overview:
Multi-lane, runtime-configurable activation unit that sits between the MAC array output stream and the writeback or next-layer stream. It is the successor to the fixed-mode activation block: lane count is parametrised, the mode is selected at run time and held for a whole packet, and it adds leaky ReLU and clipped ReLU. It has a 2-stage registered pipeline with full AXI-Stream backpressure.

Parameters:
DATA_WIDTH, 32, width of one signed two's-complement element.
LANES, 4, elements processed per beat.
FRAC_BITS, 16, fractional bits of the fixed-point format; used only by the clip threshold.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
s_axis_tvalid  in  1  input beat valid
s_axis_tready  out  1  input beat ready
s_axis_tdata  in  LANES*DATA_WIDTH  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
s_axis_tlast  in  1  last beat of packet
m_axis_tvalid  out  1  output beat valid
m_axis_tready  in  1  downstream ready
m_axis_tdata  out  LANES*DATA_WIDTH  activated lanes
m_axis_tlast  out  1  forwarded tlast
cfg_mode  in  2  0=ReLU, 1=leaky ReLU, 2=clipped ReLU, 3=bypass
cfg_shift  in  5  leaky slope alpha = 2^-cfg_shift
cfg_clip  in  DATA_WIDTH  clip ceiling, unsigned fixed-point Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS
pkt_active  out  1  high while inside a packet
stat_count  out  32  activation statistics counter (see Optional Feature)

Behaviour:
- Reset (async assert, release synchronous to clk) sets the following: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, pkt_active=0, stat_count=0, both stage valids=0, FSM=IDLE, latched config=0 (ReLU).
- s_axis_tready must be 0 while reset is asserted.
- Handshake: a transfer occurs when valid&&ready on a clock edge.
- m_axis_tvalid, m_axis_tdata and m_axis_tlast are held stable while m_axis_tvalid=1 and m_axis_tready=0.
- Pipeline: stage S1 registers the input beat and the selected config. Stage S2 registers the computed lanes and tlast.
- Stage advance rules: S2 loads when !v2 || m_axis_tready. S1 loads when !v1 || S2 loads.
- s_axis_tready = !v1 || (!v2 || m_axis_tready). A combinational ready path from m_axis_tready is permitted.
- Latency: a beat accepted at edge N appears with m_axis_tvalid=1 after edge N+2 when there is no stall.
- Throughput: 1 beat/cycle sustained with m_axis_tready=1. No beat is dropped or duplicated under any stall pattern.
- Config FSM, IDLE state:
  - The first accepted beat uses the live cfg_mode, cfg_shift and cfg_clip and latches them.
  - If that beat has tlast=0, go to IN_PKT and set pkt_active=1.
  - If that beat has tlast=1, stay in IDLE (single-beat packet).
- Config FSM, IN_PKT state:
  - Beats use the latched config. cfg_* changes are ignored.
  - An accepted beat with tlast=1 returns the FSM to IDLE and clears pkt_active after that edge.
- Per-lane arithmetic (x is signed DATA_WIDTH):
  - ReLU: x<0 gives 0, otherwise x.
  - Leaky: x<0 gives x>>>cfg_shift (arithmetic shift, rounds toward -inf, so -1 stays -1); otherwise x. cfg_shift=0 gives identity. cfg_shift>=DATA_WIDTH-1 gives -1 for any negative x.
  - Clipped: x<0 gives 0; x>cfg_clip (compared as signed, with cfg_clip treated as non-negative) gives cfg_clip; otherwise x.
  - Bypass: output = x.
  - All results are DATA_WIDTH with no overflow possible. Lanes are independent.
- Simultaneous last beat and first beat of the next packet in consecutive cycles: the new packet latches fresh config on its first beat with no bubble.
- Reset mid-packet: all in-flight beats are discarded and the FSM goes to IDLE.

Optional Feature:
Macro ACT_ENGINE_STATS_EN.
- Defined: stat_count increments once per accepted output beat (m_axis_tvalid&&m_axis_tready), by the number of lanes in that beat whose value was modified by the activation (zeroed, scaled or clipped).
  - The counter saturates at 32'hFFFFFFFF.
  - Reset clears it to 0.
- Undefined: stat_count is tied to 0 and no counter logic is instantiated.

Test Plan:
- ReLU, LANES=4: input {32'h00000010, 32'hFFFFFFF0, 32'h80000010, 0} -> output {32'h00000010, 0, 0, 0} two cycles after acceptance; stat_count=2 when enabled.
- Leaky, cfg_shift=3: input lanes -64, -1, 100, -9 -> output -8, -1, 100, -2.
- Clipped, FRAC_BITS=16, cfg_clip=32'h00060000 (6.0): input 7.0, 3.5, -2.0, 6.0 -> output 6.0, 3.5, 0, 6.0.
- Mid-packet config: 3-beat packet starting in ReLU; cfg_mode changed to bypass after beat 1 -> all 3 beats ReLU'd. The next packet's first beat uses bypass. pkt_active is high from after beat 1 to after beat 3.
- Backpressure: stream 8 beats while m_axis_tready toggles 1,0,0,1,0,... -> all 8 beats are delivered in order with correct tlast, and output stays stable during stalls.
- Reset asserted mid-packet with a full pipeline -> outputs 0 immediately, pkt_active=0. The next packet latches the live config.
